bus_dest_bank: RTL and testbench

- Destination (load) side of the 32-bit datapath bus; the counterpart of the bus source multiplexer.
- Holds every register the bus writes into: R0–R15, HI, LO, PC, MAR, MDR, Y, Z (64-bit), and InPort.
- Captures the shared bus value on per-register "in" enables.
- Presents each stored value back as a 32-bit source input for the bus multiplexer.

---
 rtl/bus_dest_bank.sv | 94 +++++++++
 tb/tb_bus_dest_bank.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_dest_bank.sv
// Destination side of the datapath bus: every bus-loadable register plus Z, PC and InPort.
// Loads take effect one edge after their enable; no handshake, enables are always accepted.
module bus_dest_bank #(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 9,
    parameter logic [DATA_W-1:0]  PC_RESET = '0
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [DATA_W-1:0]      BusMuxOut,
    input  logic [15:0]            Rin,
    input  logic                   HIin,
    input  logic                   LOin,
    input  logic                   Yin,
    input  logic                   MARin,
    input  logic                   MDRin,
    input  logic                   PCin,
    input  logic                   IncPC,
    input  logic                   Read,
    input  logic [DATA_W-1:0]      Mdatain,
    input  logic                   Zin,
    input  logic [2*DATA_W-1:0]    ALUresult,
    input  logic                   InStrobe,
    input  logic [DATA_W-1:0]      InData,
    input  logic                   BAout,
    output logic [16*DATA_W-1:0]   BusMuxInR,
    output logic [DATA_W-1:0]      BusMuxInHI,
    output logic [DATA_W-1:0]      BusMuxInLO,
    output logic [DATA_W-1:0]      BusMuxInY,
    output logic [DATA_W-1:0]      BusMuxInPC,
    output logic [DATA_W-1:0]      BusMuxInMDR,
    output logic [DATA_W-1:0]      BusMuxInInPort,
    output logic [DATA_W-1:0]      BusMuxInZhigh,
    output logic [DATA_W-1:0]      BusMuxInZlow,
    output logic [ADDR_W-1:0]      MARaddr,
    output logic                   ctl_err
);

    logic [15:0][DATA_W-1:0] r_r;
    logic [DATA_W-1:0]       r_hi, r_lo, r_y, r_pc, r_mar, r_mdr, r_inport;
    logic [DATA_W-1:0]       r_zhigh, r_zlow;
    logic                    r_ctl_err;
    logic [DATA_W-1:0]       w_r0_src;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_r       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_y       <= '0;
            r_pc      <= PC_RESET;
            r_mar     <= '0;
            r_mdr     <= '0;
            r_inport  <= '0;
            r_zhigh   <= '0;
            r_zlow    <= '0;
            r_ctl_err <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (Rin[i]) r_r[i] <= BusMuxOut;
            end
            if (HIin)  r_hi  <= BusMuxOut;
            if (LOin)  r_lo  <= BusMuxOut;
            if (Yin)   r_y   <= BusMuxOut;
            if (MARin) r_mar <= BusMuxOut;
            if (MDRin) r_mdr <= Read ? Mdatain : BusMuxOut;
            // PCin has priority; a simultaneous IncPC is a control fault flagged below
            if (PCin)       r_pc <= BusMuxOut;
            else if (IncPC) r_pc <= r_pc + DATA_W'(1);
            if (Zin) begin
                r_zhigh <= ALUresult[2*DATA_W-1:DATA_W];
                r_zlow  <= ALUresult[DATA_W-1:0];
            end
            if (InStrobe) r_inport <= InData;
            r_ctl_err <= r_ctl_err | (PCin & IncPC) | (MDRin & Read & Zin);
        end
    end

    // Base-address mode reads R0 as zero without disturbing its contents
    assign w_r0_src = BAout ? '0 : r_r[0];

    assign BusMuxInR      = {r_r[15:1], w_r0_src};
    assign BusMuxInHI     = r_hi;
    assign BusMuxInLO     = r_lo;
    assign BusMuxInY      = r_y;
    assign BusMuxInPC     = r_pc;
    assign BusMuxInMDR    = r_mdr;
    assign BusMuxInInPort = r_inport;
    assign BusMuxInZhigh  = r_zhigh;
    assign BusMuxInZlow   = r_zlow;
    assign MARaddr        = r_mar[ADDR_W-1:0];
    assign ctl_err        = r_ctl_err;

endmodule

// File: tb/tb_bus_dest_bank.sv
// Directed bench for bus_dest_bank with a queue of expected register values.
module tb_bus_dest_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic                 clock = 1'b0;
    logic                 clear;
    logic [DATA_W-1:0]    BusMuxOut;
    logic [15:0]          Rin;
    logic                 HIin, LOin, Yin, MARin, MDRin, PCin, IncPC, Read, Zin, InStrobe, BAout;
    logic [DATA_W-1:0]    Mdatain, InData;
    logic [2*DATA_W-1:0]  ALUresult;
    logic [16*DATA_W-1:0] BusMuxInR;
    logic [DATA_W-1:0]    BusMuxInHI, BusMuxInLO, BusMuxInY, BusMuxInPC, BusMuxInMDR;
    logic [DATA_W-1:0]    BusMuxInInPort, BusMuxInZhigh, BusMuxInZlow;
    logic [ADDR_W-1:0]    MARaddr;
    logic                 ctl_err;

    bus_dest_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_RESET('0)) dut (
        .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut), .Rin(Rin),
        .HIin(HIin), .LOin(LOin), .Yin(Yin), .MARin(MARin), .MDRin(MDRin),
        .PCin(PCin), .IncPC(IncPC), .Read(Read), .Mdatain(Mdatain), .Zin(Zin),
        .ALUresult(ALUresult), .InStrobe(InStrobe), .InData(InData), .BAout(BAout),
        .BusMuxInR(BusMuxInR), .BusMuxInHI(BusMuxInHI), .BusMuxInLO(BusMuxInLO),
        .BusMuxInY(BusMuxInY), .BusMuxInPC(BusMuxInPC), .BusMuxInMDR(BusMuxInMDR),
        .BusMuxInInPort(BusMuxInInPort), .BusMuxInZhigh(BusMuxInZhigh),
        .BusMuxInZlow(BusMuxInZlow), .MARaddr(MARaddr), .ctl_err(ctl_err)
    );

    always #5 clock = ~clock;

    // Observable selectors: 0..15 R slices, then named registers
    localparam int S_HI = 16, S_LO = 17, S_Y = 18, S_PC = 19, S_MDR = 20, S_IN = 21;
    localparam int S_ZH = 22, S_ZL = 23, S_MAR = 24, S_ERR = 25, S_NUM = 26;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] get_obs(input int sel);
        logic [31:0] v;
        v = '0;
        if (sel < 16) v = BusMuxInR[sel*DATA_W +: DATA_W];
        else case (sel)
            S_HI:  v = BusMuxInHI;
            S_LO:  v = BusMuxInLO;
            S_Y:   v = BusMuxInY;
            S_PC:  v = BusMuxInPC;
            S_MDR: v = BusMuxInMDR;
            S_IN:  v = BusMuxInInPort;
            S_ZH:  v = BusMuxInZhigh;
            S_ZL:  v = BusMuxInZlow;
            S_MAR: v = {{(32-ADDR_W){1'b0}}, MARaddr};
            S_ERR: v = {31'b0, ctl_err};
            default: v = 'x;
        endcase
        return v;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    // Expect every observable to be zero except the ones pushed afterwards by the caller
    task automatic push_all_zero(input string tag, input int skip);
        for (int s = 0; s < S_NUM; s++)
            if (s != skip) push($sformatf("%s_s%0d", tag, s), s, 32'h0);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = get_obs(e.sel);
            n_cmp++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        clear = 1'b1; BusMuxOut = '0; Rin = '0;
        HIin = 0; LOin = 0; Yin = 0; MARin = 0; MDRin = 0; PCin = 0; IncPC = 0;
        Read = 0; Zin = 0; InStrobe = 0; BAout = 0;
        Mdatain = '0; InData = '0; ALUresult = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drain();
        idle();
    endtask

    initial begin
        idle();
        // 1: reset, then broadcast to R0, R2, R15
        clear = 1'b0; BusMuxOut = 32'hFFFF_FFFF; Rin = 16'hFFFF; PCin = 1;
        push_all_zero("reset", -1);
        step();
        BusMuxOut = 32'hA5A5_0001; Rin = 16'h8005;
        for (int i = 0; i < 16; i++)
            push($sformatf("bcast_r%0d", i), i,
                 (i == 0 || i == 2 || i == 15) ? 32'hA5A5_0001 : 32'h0);
        step();

        // 2: BAout gating of R0
        BusMuxOut = 32'h1234; Rin = 16'h0001;
        push("r0_load", 0, 32'h1234);
        step();
        BAout = 1; #1;
        push("r0_gated", 0, 32'h0);
        drain();
        BAout = 0; #1;
        push("r0_ungated", 0, 32'h1234);
        drain();
        BAout = 1; BusMuxOut = 32'hFFFF;
        push("r0_gated_clk", 0, 32'h0);
        push("r2_hold", 2, 32'hA5A5_0001);
        @(posedge clock); #1; drain();
        BAout = 0; #1;
        push("r0_kept", 0, 32'h1234);
        drain();
        idle();

        // 3: PC load, increment, wrap, conflicting strobes
        BusMuxOut = 32'hFFFF_FFFE; PCin = 1;
        push("pc_load", S_PC, 32'hFFFF_FFFE);
        push("err_clean", S_ERR, 32'h0);
        step();
        IncPC = 1;
        push("pc_inc", S_PC, 32'hFFFF_FFFF);
        step();
        IncPC = 1;
        push("pc_wrap", S_PC, 32'h0);
        step();
        BusMuxOut = 32'h40; PCin = 1; IncPC = 1;
        push("pc_prio", S_PC, 32'h40);
        push("err_set", S_ERR, 32'h1);
        step();
        push("pc_hold", S_PC, 32'h40);
        push("err_sticky", S_ERR, 32'h1);
        step();

        // 4: MAR and MDR
        BusMuxOut = 32'h0000_03FF; MARin = 1;
        push("mar_addr", S_MAR, 32'h1FF);
        step();
        BusMuxOut = 32'h11; MDRin = 1; Read = 1; Mdatain = 32'hDEAD_BEEF;
        push("mdr_mem", S_MDR, 32'hDEAD_BEEF);
        step();
        BusMuxOut = 32'h77; MDRin = 1; Mdatain = 32'h1111_2222;
        push("mdr_bus", S_MDR, 32'h77);
        step();
        Read = 1; Mdatain = 32'h3333_4444;
        push("mdr_read_only", S_MDR, 32'h77);
        step();

        // 5: Z, HI/LO broadcast, Y
        Zin = 1; ALUresult = 64'h0000_0002_8000_0000; BusMuxOut = 32'hABCD;
        push("z_high", S_ZH, 32'h2);
        push("z_low", S_ZL, 32'h8000_0000);
        step();
        BusMuxOut = 32'h9; HIin = 1; LOin = 1;
        push("hi", S_HI, 32'h9);
        push("lo", S_LO, 32'h9);
        push("y_hold", S_Y, 32'h0);
        step();
        BusMuxOut = 32'h3C; Yin = 1;
        push("y", S_Y, 32'h3C);
        step();

        // 6: reset wins over same-cycle loads, then InPort alone
        clear = 1'b0; Rin = 16'hFFFF; Zin = 1; InStrobe = 1; InData = 32'hAA;
        BusMuxOut = 32'h5A5A; ALUresult = 64'hFFFF_FFFF_FFFF_FFFF;
        push_all_zero("rst_mid", -1);
        step();
        InStrobe = 1; InData = 32'h55; BusMuxOut = 32'h99;
        push_all_zero("inport_only", S_IN);
        push("inport", S_IN, 32'h55);
        step();

        // Memory read overlapping ALU writeback: flag it but still perform both loads
        MDRin = 1; Read = 1; Zin = 1; Mdatain = 32'hCAFE; ALUresult = 64'h1_0000_0007;
        push("err_mdr_z", S_ERR, 32'h1);
        push("mdr_conflict", S_MDR, 32'hCAFE);
        push("zl_conflict", S_ZL, 32'h7);
        push("zh_conflict", S_ZH, 32'h1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
